keypad_scanner: RTL and testbench

Input-side counterpart of the multiplexed seven-segment display driver. The display strobes anodes to drive outputs; this block strobes the columns of a 4x4 matrix keypad and reads its rows back. It debounces the result and emits one key code per press. It feeds the calculator's data/enter path in place of the switches and buttons.

---
 rtl/keypad_pkg.sv | 42 ++++
 rtl/keypad_row_sync.sv | 27 ++
 rtl/keypad_scanner.sv | 198 +++++++++++++++++++
 tb/tb_keypad_scanner.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/keypad_pkg.sv
// Shared types and helpers for the 4x4 matrix keypad scanner.
// Key codes are row*4+col, so a code is simply {row, col}.
package keypad_pkg;

  localparam int KEY_ROWS   = 4;
  localparam int KEY_COLS   = 4;
  localparam int KEY_CODE_W = 4;

  typedef enum logic [1:0] {
    IDLE,
    CAND,
    PRESSED,
    RELEASE
  } scan_state_t;

  typedef enum logic [1:0] {
    NONE,
    SINGLE,
    MULTI
  } frame_res_t;

  // Number of rows pulled low in one column sample.
  function automatic logic [2:0] low_count(input logic [KEY_ROWS-1:0] r);
    logic [2:0] n;
    n = '0;
    for (int i = 0; i < KEY_ROWS; i++) begin
      if (!r[i]) n = n + 3'd1;
    end
    return n;
  endfunction

  // Index of the lowest-numbered row pulled low; only meaningful when exactly one is.
  function automatic logic [1:0] low_row(input logic [KEY_ROWS-1:0] r);
    logic [1:0] idx;
    idx = '0;
    for (int i = KEY_ROWS - 1; i >= 0; i--) begin
      if (!r[i]) idx = 2'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/keypad_row_sync.sv
// Two-flop synchroniser for the asynchronous keypad row lines.
// Resets to all-ones, i.e. "no row pulled low".
module keypad_row_sync
  import keypad_pkg::*;
(
  input  logic                clock,
  input  logic                reset,
  input  logic [KEY_ROWS-1:0] rows,
  output logic [KEY_ROWS-1:0] rows_sync
);

  logic [KEY_ROWS-1:0] rows_p0;
  logic [KEY_ROWS-1:0] rows_p1;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rows_p0 <= '1;
      rows_p1 <= '1;
    end else begin
      rows_p0 <= rows;
      rows_p1 <= rows_p0;
    end
  end

  assign rows_sync = rows_p1;

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 keypad column scanner with frame debounce; one key_valid per accepted press.
// Define KEYPAD_SCANNER_AUTOREPEAT_EN to re-pulse key_valid while a key stays held.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV        = 1000,
  parameter int DEBOUNCE_FRAMES = 4
`ifdef KEYPAD_SCANNER_AUTOREPEAT_EN
  ,
  parameter int REPEAT_DELAY    = 32,
  parameter int REPEAT_RATE     = 8
`endif
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [KEY_ROWS-1:0]   rows,
  output logic [KEY_COLS-1:0]   columns,
  output logic [KEY_CODE_W-1:0] key_code,
  output logic                  key_valid,
  output logic                  key_down,
  output logic                  multi_key
);

  localparam int                SLOT_W    = $clog2(SCAN_DIV);
  localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(SCAN_DIV - 1);
  localparam logic [4:0]        DEB_N     = 5'(DEBOUNCE_FRAMES);

  logic [KEY_ROWS-1:0]   rows_sync;
  logic                  running;
  logic [SLOT_W-1:0]     slot_cnt;
  logic [1:0]            col_idx;
  logic                  slot_end;
  logic                  frame_end;
  logic [1:0]            acc_cnt;
  logic [KEY_CODE_W-1:0] acc_code;
  logic [2:0]            col_hits;
  logic [2:0]            tally;
  logic [KEY_CODE_W-1:0] frame_code;
  frame_res_t            frame_res;
  scan_state_t           state;
  logic [KEY_CODE_W-1:0] cand;
  logic [3:0]            deb_cnt;
  logic [4:0]            deb_inc;
  logic                  hit_cand;
  logic                  cand_start;
  logic                  accept;

  keypad_row_sync u_row_sync (
    .clock     (clock),
    .reset     (reset),
    .rows      (rows),
    .rows_sync (rows_sync)
  );

  always_comb begin
    slot_end   = running && (slot_cnt == SLOT_LAST);
    frame_end  = slot_end && (col_idx == 2'd3);
    col_hits   = low_count(rows_sync);
    tally      = {1'b0, acc_cnt} + col_hits;
    frame_code = (acc_cnt == 2'd0) ? {low_row(rows_sync), col_idx} : acc_code;
    if (tally == 3'd0)      frame_res = NONE;
    else if (tally == 3'd1) frame_res = SINGLE;
    else                    frame_res = MULTI;
    hit_cand   = (frame_res == SINGLE) && (frame_code == cand);
    deb_inc    = {1'b0, deb_cnt} + 5'd1;
    cand_start = frame_end && (frame_res == SINGLE) &&
                 ((state == IDLE) || (!hit_cand && ((state == CAND) || (state == RELEASE))));
    accept     = (cand_start && (DEB_N == 5'd1)) ||
                 (frame_end && (state == CAND) && hit_cand && (deb_inc >= DEB_N));
  end

`ifdef KEYPAD_SCANNER_AUTOREPEAT_EN
  localparam int REP_W = $clog2(REPEAT_DELAY + REPEAT_RATE + 1) + 1;

  logic [REP_W-1:0] rep_cnt;
  logic [REP_W-1:0] rep_next;
  logic [REP_W-1:0] rep_target;
  logic             rep_first;

  always_comb begin
    rep_next   = rep_cnt + REP_W'(1);
    rep_target = rep_first ? REP_W'(REPEAT_DELAY) : REP_W'(REPEAT_RATE);
  end
`endif

  // Column strobe: idle-high until the first clock after reset, then one slot per column.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      running  <= 1'b0;
      slot_cnt <= '0;
      col_idx  <= '0;
      columns  <= '1;
    end else if (!running) begin
      running <= 1'b1;
      columns <= 4'b1110;
    end else if (slot_end) begin
      slot_cnt <= '0;
      col_idx  <= col_idx + 2'd1;
      columns  <= ~(4'b0001 << (col_idx + 2'd1));
    end else begin
      slot_cnt <= slot_cnt + SLOT_W'(1);
    end
  end

  // Per-frame key tally; saturates at 2 since only "none / one / many" matters.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      acc_cnt  <= '0;
      acc_code <= '0;
    end else if (slot_end) begin
      if (col_idx == 2'd3) begin
        acc_cnt  <= '0;
        acc_code <= '0;
      end else begin
        acc_cnt  <= (tally >= 3'd2) ? 2'd2 : tally[1:0];
        acc_code <= frame_code;
      end
    end
  end

  // Debounce FSM, stepped once per evaluated frame.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      cand      <= '0;
      deb_cnt   <= '0;
      key_code  <= '0;
      key_valid <= 1'b0;
      key_down  <= 1'b0;
      multi_key <= 1'b0;
`ifdef KEYPAD_SCANNER_AUTOREPEAT_EN
      rep_cnt   <= '0;
      rep_first <= 1'b0;
`endif
    end else begin
      key_valid <= 1'b0;
      if (frame_end) begin
        multi_key <= (frame_res == MULTI);
        if (accept) begin
          state     <= PRESSED;
          cand      <= frame_code;
          key_code  <= frame_code;
          key_valid <= 1'b1;
          key_down  <= 1'b1;
`ifdef KEYPAD_SCANNER_AUTOREPEAT_EN
          rep_cnt   <= '0;
          rep_first <= 1'b1;
`endif
        end else if (cand_start) begin
          state    <= CAND;
          cand     <= frame_code;
          deb_cnt  <= 4'd1;
          key_down <= 1'b0;
        end else begin
          case (state)
            CAND: begin
              if (hit_cand) deb_cnt <= deb_inc[3:0];
              else          state   <= IDLE;
            end
            PRESSED: begin
              if (!hit_cand) begin
                if (DEB_N == 5'd1) begin
                  state    <= IDLE;
                  key_down <= 1'b0;
                end else begin
                  state   <= RELEASE;
                  deb_cnt <= 4'd1;
                end
              end
`ifdef KEYPAD_SCANNER_AUTOREPEAT_EN
              else if (rep_next == rep_target) begin
                key_valid <= 1'b1;
                rep_cnt   <= '0;
                rep_first <= 1'b0;
              end else begin
                rep_cnt <= rep_next;
              end
`endif
            end
            RELEASE: begin
              // Repeat counter deliberately left untouched here so a bounce resumes it.
              if (hit_cand) begin
                state <= PRESSED;
              end else if (deb_inc >= DEB_N) begin
                state    <= IDLE;
                key_down <= 1'b0;
              end else begin
                deb_cnt <= deb_inc[3:0];
              end
            end
            default: ;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: frame-level key model checked every cycle plus directed literals.
`timescale 1ns/1ps
module tb_keypad_scanner;

  localparam int SD = 4;
  localparam int DF = 4;
  localparam int FR = 4 * SD;
`ifdef KEYPAD_SCANNER_AUTOREPEAT_EN
  localparam int RD = 5;
  localparam int RR = 2;
`endif

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] rows;
  logic [3:0] columns;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_down;
  logic       multi_key;
  logic [15:0] keys = '0;

  int n_cmp = 0;
  int n_bad = 0;
  int valid_seen = 0;
  int multi_seen = 0;
  int last_code = 0;

  always #5 clock = ~clock;

  keypad_scanner #(
    .SCAN_DIV        (SD),
    .DEBOUNCE_FRAMES (DF)
`ifdef KEYPAD_SCANNER_AUTOREPEAT_EN
    ,
    .REPEAT_DELAY    (RD),
    .REPEAT_RATE     (RR)
`endif
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .rows      (rows),
    .columns   (columns),
    .key_code  (key_code),
    .key_valid (key_valid),
    .key_down  (key_down),
    .multi_key (multi_key)
  );

  // Passive matrix: a pressed key shorts its row to its column when that column is strobed low.
  always_comb begin
    rows = 4'hF;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (keys[r * 4 + c] && !columns[c]) rows[r] = 1'b0;
      end
    end
  end

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Frame-level model: expected outputs after each clock edge since reset release.
  int         cyc;
  logic [3:0] e_cols;
  logic [3:0] e_code;
  logic       e_valid, e_down, e_multi;
  int         down_key, cand_key, run, quiet, rep, rep_first;

  task automatic take_key(input int c);
    down_key  = c;
    e_code    = 4'(c);
    e_valid   = 1'b1;
    e_down    = 1'b1;
    quiet     = 0;
    rep       = 0;
    rep_first = 1;
  endtask

  task automatic eval_frame();
    int n;
    int c;
    n = $countones(keys);
    c = 0;
    for (int i = 15; i >= 0; i--) if (keys[i]) c = i;
    e_multi = (n >= 2);
    if (down_key < 0) begin
      if (n == 1) begin
        run = (c == cand_key && run > 0) ? run + 1 : 1;
        cand_key = c;
        if (run >= DF) take_key(c);
      end else begin
        run = 0;
      end
    end else if (n == 1 && c == down_key) begin
      if (quiet == 0) begin
`ifdef KEYPAD_SCANNER_AUTOREPEAT_EN
        rep++;
        if (rep == (rep_first != 0 ? RD : RR)) begin
          e_valid   = 1'b1;
          rep       = 0;
          rep_first = 0;
        end
`endif
      end else begin
        quiet = 0;
      end
    end else if (quiet > 0 && n == 1) begin
      down_key = -1;
      e_down   = 1'b0;
      cand_key = c;
      run      = 1;
      if (DF == 1) take_key(c);
    end else begin
      quiet++;
      if (quiet >= DF) begin
        down_key = -1;
        e_down   = 1'b0;
        run      = 0;
      end
    end
  endtask

  always @(negedge clock) begin
    if (!reset) begin
      cyc = 0; e_cols = 4'hF; e_code = '0; e_valid = 1'b0; e_down = 1'b0; e_multi = 1'b0;
      down_key = -1; cand_key = -1; run = 0; quiet = 0; rep = 0; rep_first = 0;
    end else begin
      cyc++;
      e_valid = 1'b0;
      e_cols  = ~(4'b0001 << (((cyc - 1) / SD) % 4));
      if (cyc > 1 && (cyc - 1) % FR == 0) eval_frame();
    end
    check("columns",   int'(columns),   int'(e_cols));
    check("key_code",  int'(key_code),  int'(e_code));
    check("key_valid", int'(key_valid), int'(e_valid));
    check("key_down",  int'(key_down),  int'(e_down));
    check("multi_key", int'(multi_key), int'(e_multi));
    if (key_valid) begin
      valid_seen++;
      last_code = int'(key_code);
    end
    if (multi_key) multi_seen++;
  end

  // Advance n whole frames, ending just after an evaluation edge.
  task automatic frames(input int n);
    repeat (n * FR) @(posedge clock);
    @(negedge clock);
    #1;
  endtask

  logic [3:0] scan_exp [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
  int v0, m0;

  initial begin
    #1 reset = 1'b0;
    repeat (3) @(negedge clock);
    #1;
    check("rst_columns",   int'(columns),   15);
    check("rst_key_code",  int'(key_code),  0);
    check("rst_key_valid", int'(key_valid), 0);
    check("rst_key_down",  int'(key_down),  0);
    check("rst_multi_key", int'(multi_key), 0);
    reset = 1'b1;

    // Idle scan sequence
    for (int i = 0; i < 5; i++) begin
      if (i == 0) @(posedge clock);
      else        repeat (SD) @(posedge clock);
      #1 check("scan_columns", int'(columns), int'(scan_exp[i % 4]));
    end
    @(negedge clock); #1;
    v0 = valid_seen;
    frames(2);
    check("idle_no_valid", valid_seen - v0, 0);

    // Clean press of key 9 (row 2, column 1)
    keys[9] = 1'b1;
    v0 = valid_seen;
    frames(6);
    check("clean_valid_count", valid_seen - v0, 1);
    check("clean_code", last_code, 9);
    check("clean_down_held", int'(key_down), 1);
    keys = '0;
    frames(3);
    check("clean_down_release3", int'(key_down), 1);
    frames(1);
    check("clean_down_release4", int'(key_down), 0);

    // Bouncing key 5, then held
    v0 = valid_seen;
    for (int i = 0; i < 10; i++) begin
      keys[5] = (i % 2 == 0);
      frames(1);
    end
    check("bounce_no_valid", valid_seen - v0, 0);
    keys[5] = 1'b1;
    frames(3);
    check("bounce_three_stable", valid_seen - v0, 0);
    frames(1);
    check("bounce_valid_count", valid_seen - v0, 1);
    check("bounce_code", last_code, 5);
    keys = '0;
    frames(4);

    // Keys 0 and 15 together, then 15 released
    keys[0]  = 1'b1;
    keys[15] = 1'b1;
    v0 = valid_seen;
    m0 = multi_seen;
    frames(6);
    check("multi_no_valid", valid_seen - v0, 0);
    check("multi_cycles", multi_seen - m0, 5 * FR + 1);
    keys[15] = 1'b0;
    frames(3);
    check("multi_then_three", valid_seen - v0, 0);
    frames(1);
    check("multi_then_valid", valid_seen - v0, 1);
    check("multi_then_code", last_code, 0);
    keys = '0;
    frames(4);

    // Reset while key 6 is pressed
    keys[6] = 1'b1;
    v0 = valid_seen;
    frames(5);
    check("midrst_first_valid", valid_seen - v0, 1);
    repeat (5) @(posedge clock);
    #2 reset = 1'b0;
    #1;
    check("midrst_columns",   int'(columns),   15);
    check("midrst_key_code",  int'(key_code),  0);
    check("midrst_key_valid", int'(key_valid), 0);
    check("midrst_key_down",  int'(key_down),  0);
    check("midrst_multi_key", int'(multi_key), 0);
    @(negedge clock);
    #2 reset = 1'b1;
    @(posedge clock);
    @(negedge clock); #1;
    v0 = valid_seen;
    frames(3);
    check("midrst_three", valid_seen - v0, 0);
    frames(1);
    check("midrst_again_valid", valid_seen - v0, 1);
    check("midrst_again_code", last_code, 6);
    keys = '0;
    frames(4);

`ifdef KEYPAD_SCANNER_AUTOREPEAT_EN
    // Key 7 held: pulses at acceptance, then +5, +7, +9, +11 frames
    keys[7] = 1'b1;
    v0 = valid_seen;
    frames(4);
    check("rep_accept", valid_seen - v0, 1);
    for (int f = 1; f <= 12; f++) begin
      v0 = valid_seen;
      frames(1);
      check("rep_frame_pulse", valid_seen - v0, (f == 5 || f == 7 || f == 9 || f == 11) ? 1 : 0);
    end
    check("rep_code", last_code, 7);
    keys = '0;
    frames(4);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
